// File: rtl/com_seq_if.sv
// Bytecode-request, ROM lookup and emitted-word handshake bundle for com_seq.
// master: the environment side (requester, ROM, consumer); slave: com_seq itself.
interface com_seq_if;
  logic        op_valid;
  logic [1:0]  op_code;
  logic        op_ready;
  logic [2:0]  rom_addr;
  logic [31:0] rom_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        seq_done;
  logic        err;

  modport master (
    output op_valid, op_code, rom_data, out_ready,
    input  op_ready, rom_addr, out_valid, out_data, seq_done, err
  );

  modport slave (
    input  op_valid, op_code, rom_data, out_ready,
    output op_ready, rom_addr, out_valid, out_data, seq_done, err
  );
endinterface

// File: rtl/com_seq.sv
// Bytecode-to-ARM sequencer: expands IADD/ISUB into three ROM-sourced words.
// Optional COM_SEQ_SKIP_ZERO_EN: all-zero ROM words are skipped instead of emitted.
module com_seq (
  input  logic       clk,
  input  logic       rst,
  com_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    EMIT,
    WAIT,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_IADD = 2'd1;
  localparam logic [1:0] OP_ISUB = 2'd2;

  localparam logic [2:0] ADDR_POP2 = 3'd1;
  localparam logic [2:0] ADDR_ADD  = 3'd2;
  localparam logic [2:0] ADDR_PUSH = 3'd3;
  localparam logic [2:0] ADDR_SUB  = 3'd4;

  localparam logic [1:0] LAST_STEP = 2'd2;

  state_t      state, state_nx;
  logic [1:0]  step, step_nx;
  logic        is_sub, is_sub_nx;
  logic        out_valid_q, out_valid_nx;
  logic [31:0] out_data_q, out_data_nx;
  logic        err_q, err_nx;
  logic [2:0]  step_addr;

  // The middle step is the only one that differs between IADD and ISUB.
  always_comb begin
    step_addr = ADDR_POP2;
    case (step)
      2'd0:    step_addr = ADDR_POP2;
      2'd1:    step_addr = is_sub ? ADDR_SUB : ADDR_ADD;
      default: step_addr = ADDR_PUSH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      step        <= '0;
      is_sub      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nx;
      step        <= step_nx;
      is_sub      <= is_sub_nx;
      out_valid_q <= out_valid_nx;
      out_data_q  <= out_data_nx;
      err_q       <= err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    step_nx      = step;
    is_sub_nx    = is_sub;
    out_valid_nx = out_valid_q;
    out_data_nx  = out_data_q;
    err_nx       = err_q;

    case (state)
      IDLE: begin
        if (bus.op_valid) begin
          case (bus.op_code)
            OP_NOP: state_nx = DONE;
            OP_IADD: begin
              state_nx  = EMIT;
              step_nx   = '0;
              is_sub_nx = 1'b0;
            end
            OP_ISUB: begin
              state_nx  = EMIT;
              step_nx   = '0;
              is_sub_nx = 1'b1;
            end
            default: begin
              state_nx = ERR;
              err_nx   = 1'b1;
            end
          endcase
        end
      end

      EMIT: begin
        if (bus.rom_data == '1) begin
          state_nx = ERR;
          err_nx   = 1'b1;
        end
`ifdef COM_SEQ_SKIP_ZERO_EN
        else if (bus.rom_data == '0) begin
          // Skipped word consumes its step without an out_valid cycle.
          if (step == LAST_STEP) begin
            state_nx = DONE;
            step_nx  = '0;
          end else begin
            state_nx = EMIT;
            step_nx  = step + 2'd1;
          end
        end
`endif
        else begin
          out_data_nx  = bus.rom_data;
          out_valid_nx = 1'b1;
          state_nx     = WAIT;
        end
      end

      WAIT: begin
        if (bus.out_ready) begin
          out_valid_nx = 1'b0;
          if (step == LAST_STEP) begin
            state_nx = DONE;
            step_nx  = '0;
          end else begin
            state_nx = EMIT;
            step_nx  = step + 2'd1;
          end
        end
      end

      DONE: state_nx = IDLE;

      ERR: begin
        state_nx     = ERR;
        out_valid_nx = 1'b0;
        err_nx       = 1'b1;
      end

      default: state_nx = IDLE;
    endcase
  end

  assign bus.op_ready  = (state == IDLE);
  assign bus.rom_addr  = (state == EMIT) ? step_addr : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.seq_done  = (state == DONE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_com_seq.sv
// Randomized bench for com_seq against a transaction-level expansion model.
module tb_com_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  com_seq_if bus ();

  com_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] rom [0:7];
  assign bus.rom_data = rom[bus.rom_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic load_canonical_rom();
    for (int i = 0; i < 8; i++) rom[i] = 32'hFFFF_FFFF;
    rom[1] = 32'hE83D_0003;
    rom[2] = 32'hE080_0001;
    rom[3] = 32'hE9AD_0001;
    rom[4] = 32'hE040_0001;
  endtask

  // Reset is raised mid-cycle so the outputs are checked before any clock edge.
  task automatic do_reset();
    bus.op_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data",  bus.out_data,       32'd0);
    check_eq("rst_seq_done",  32'(bus.seq_done),  32'd0);
    check_eq("rst_err",       32'(bus.err),       32'd0);
    check_eq("rst_op_ready",  32'(bus.op_ready),  32'd1);
    check_eq("rst_rom_addr",  32'(bus.rom_addr),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rel_op_ready", 32'(bus.op_ready), 32'd1);
    @(negedge clk);
  endtask

  // Issue one op and follow it to completion; expected words come from the ROM
  // contents and the op's address list, with 2-cycle gaps plus one per skipped word.
  task automatic run_op(input logic [1:0] code, input int stall_pct,
                        input int hold_idx, input int hold_n);
    logic [31:0] exp_w[$];
    int          exp_gap[$];
    bit          exp_err;
    int          skips;
    int          tail;
    int          a;
    logic [31:0] w;
    int          got;
    int          cnt;
    int          stall_left;
    int          wait_n;
    bit          in_word;
    bit          done_seen;
    logic [31:0] held;

    exp_err = 1'b0; skips = 0; got = 0; cnt = 0; stall_left = 0; wait_n = 0;
    in_word = 1'b0; done_seen = 1'b0; held = '0;

    if (code == 2'd3) exp_err = 1'b1;
    else if (code != 2'd0) begin
      for (int i = 0; i < 3; i++) begin
        a = (i == 0) ? 1 : (i == 2) ? 3 : (code == 2'd2) ? 4 : 2;
        w = rom[a];
        if (w == 32'hFFFF_FFFF) begin
          exp_err = 1'b1;
          break;
        end
`ifdef COM_SEQ_SKIP_ZERO_EN
        if (w == 32'h0) begin
          skips++;
          continue;
        end
`endif
        exp_w.push_back(w);
        exp_gap.push_back(2 + skips);
        skips = 0;
      end
    end
    tail = 1 + skips;

    while (!bus.op_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check_eq("op_ready_idle", 32'(bus.op_ready), 32'd1);

    bus.op_valid = 1'b1;
    bus.op_code  = code;
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_code  = 2'($urandom);
    cnt = 1;
    if (code == 2'd1 || code == 2'd2)
      check_eq("rom_addr_first", 32'(bus.rom_addr), 32'd1);

    for (int cyc = 0; cyc < 200; cyc++) begin
      if (bus.seq_done) begin
        done_seen = 1'b1;
        check_eq("done_gap", 32'(cnt), 32'(tail));
        check_eq("done_out_valid", 32'(bus.out_valid), 32'd0);
        break;
      end
      if (bus.err) break;
      if (bus.out_valid) begin
        check_eq("wait_rom_addr", 32'(bus.rom_addr), 32'd0);
        if (!in_word) begin
          in_word    = 1'b1;
          held       = bus.out_data;
          stall_left = (got == hold_idx) ? hold_n : 0;
          if (got < exp_w.size()) begin
            check_eq("word_gap",  32'(cnt), 32'(exp_gap[got]));
            check_eq("word_data", bus.out_data, exp_w[got]);
          end else
            check_eq("extra_word", 32'(got + 1), 32'(exp_w.size()));
        end else
          check_eq("word_stable", bus.out_data, held);
        if (stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
        end else
          bus.out_ready = ($urandom_range(99) >= stall_pct);
        if (bus.out_ready) begin
          got++;
          in_word = 1'b0;
          cnt = 0;
        end
      end else
        bus.out_ready = 1'($urandom_range(1));
      @(negedge clk);
      cnt++;
    end

    check_eq("word_count", 32'(got), 32'(exp_w.size()));
    check_eq("err_flag",   32'(bus.err), 32'(exp_err));
    check_eq("done_seen",  32'(done_seen), 32'(!exp_err));

    if (done_seen) begin
      @(negedge clk);
      check_eq("done_one_cycle", 32'(bus.seq_done), 32'd0);
      check_eq("op_ready_after", 32'(bus.op_ready), 32'd1);
    end

    if (exp_err) begin
      for (int k = 0; k < 3; k++) begin
        bus.op_valid  = 1'b1;
        bus.op_code   = 2'($urandom);
        bus.out_ready = 1'($urandom_range(1));
        @(negedge clk);
        check_eq("err_op_ready",  32'(bus.op_ready),  32'd0);
        check_eq("err_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("err_sticky",    32'(bus.err),       32'd1);
      end
      bus.op_valid = 1'b0;
      do_reset();
    end
  endtask

  initial begin
    int wait_n;
    bus.op_valid  = 1'b0;
    bus.op_code   = 2'd0;
    bus.out_ready = 1'b0;
    load_canonical_rom();
    @(negedge clk);
    do_reset();

    // Canonical IADD with consumer always ready.
    run_op(2'd1, 0, -1, 0);
    // ISUB with the second word stalled five cycles.
    run_op(2'd2, 0, 1, 5);
    // NOP: no words, immediate done.
    run_op(2'd0, 0, -1, 0);
    // Reserved op code: sticky error until reset.
    run_op(2'd3, 0, -1, 0);
    // Unmapped ROM entry on the IADD second step.
    rom[2] = 32'hFFFF_FFFF;
    run_op(2'd1, 0, -1, 0);
    // Zero word: skipped or emitted depending on build.
    rom[2] = 32'h0;
    run_op(2'd1, 0, -1, 0);
    load_canonical_rom();

    // Reset while the first IADD word waits for the consumer.
    bus.out_ready = 1'b0;
    bus.op_valid  = 1'b1;
    bus.op_code   = 2'd1;
    @(negedge clk);
    bus.op_valid = 1'b0;
    wait_n = 0;
    while (!bus.out_valid && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    check_eq("abort_pre_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_seq_done",  32'(bus.seq_done),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("abort_quiet_valid", 32'(bus.out_valid), 32'd0);
      check_eq("abort_quiet_done",  32'(bus.seq_done),  32'd0);
    end
    run_op(2'd1, 0, -1, 0);

    // Randomized ops over randomized ROM contents.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] code;
      for (int i = 0; i < 8; i++) begin
        if (i >= 1 && i <= 4) begin
          case ($urandom_range(9))
            0:       rom[i] = 32'hFFFF_FFFF;
            1:       rom[i] = 32'h0;
            default: rom[i] = $urandom;
          endcase
        end else
          rom[i] = 32'hFFFF_FFFF;
      end
      code = ($urandom_range(19) == 0) ? 2'd3 : 2'($urandom_range(2));
      run_op(code, int'($urandom_range(60)), -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/com_seq.md
COM_SEQ -- requirements
Module: com_seq

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  asynchronous, active-high reset.
REQ-003: op_valid  input  1  bytecode class request present.
REQ-004: op_code  input  2  bytecode class: 0=NOP, 1=IADD, 2=ISUB, 3=reserved.
REQ-005: op_ready  output  1  high only in IDLE; request accepted when op_valid&op_ready.
REQ-006: rom_addr  output  3  address to the combinational instruction ROM.
REQ-007: rom_data  input  32  ARM instruction word returned by the ROM in the same cycle.
REQ-008: out_valid  output  1  out_data holds an emitted instruction.
REQ-009: out_data  output  32  emitted ARM instruction word.
REQ-010: out_ready  input  1  consumer accepts out_data when out_valid&out_ready.
REQ-011: seq_done  output  1  one-cycle pulse when a sequence completes.
REQ-012: err  output  1  sticky error flag.

Function
REQ-013: ROM address map SHALL be: 1=pop-two (LDMDA sp!), 2=ADD, 3=push (STMIB sp!), 4=SUB.
REQ-014: Sequences SHALL be: IADD = {1,2,3}; ISUB = {1,4,3}; NOP = empty; each step is one emitted word.
REQ-015: States SHALL be IDLE, EMIT, WAIT, DONE, ERR; reset state is IDLE.
REQ-016: IDLE: on accepted NOP -> DONE; on accepted IADD/ISUB -> EMIT with step index 0; on accepted op_code 3 -> ERR with err set.
REQ-017: EMIT: rom_addr SHALL be the current step's address; rom_data SHALL be registered into out_data with out_valid set; next state WAIT.
REQ-018: WAIT: out_data and out_valid SHALL be held stable until out_ready; on accept, step index increments -> EMIT, or -> DONE after the third step.
REQ-019: Latency SHALL be: accept -> first out_valid = 2 cycles; word accept -> next out_valid = 2 cycles with out_ready held high.
REQ-020: DONE SHALL assert seq_done for exactly one cycle and return to IDLE; out_valid is low in DONE.
REQ-021: rom_data equal to 32'hFFFFFFFF (unmapped ROM entry) in EMIT SHALL set err, suppress the word (out_valid stays low) and go to ERR.
REQ-022: ERR SHALL hold op_ready low and out_valid low until reset; err stays high.
REQ-023: op_valid while op_ready is low SHALL be ignored; op_code is sampled only on acceptance.
REQ-024: rom_addr SHALL be 3'b000 whenever not in EMIT.
REQ-025: The step index SHALL be 2 bits and never exceed 2; no wrap into a fourth step.

Reset
REQ-026: rst SHALL asynchronously force state IDLE, step index 0, out_valid 0, out_data 32'h0, seq_done 0, err 0.
REQ-027: rst asserted mid-sequence SHALL abort it with no further words or seq_done; after release op_ready is high on the first clock.

Configuration
REQ-028: Macro COM_SEQ_SKIP_ZERO_EN defined: a rom_data of 32'h0 in EMIT SHALL not be emitted; the step advances directly (EMIT -> EMIT or DONE) with no out_valid cycle.
REQ-029: Macro COM_SEQ_SKIP_ZERO_EN undefined: 32'h0 SHALL be emitted as an ordinary word.

Verification
REQ-030: IADD, out_ready=1, ROM {1:E83D0003,2:E0800001,3:E9AD0001} -> out_data sequence E83D0003, E0800001, E9AD0001; seq_done 1 cycle after the third accept.
REQ-031: ISUB with out_ready low for 5 cycles on the second word -> E0400001 held stable for 5 cycles; sequence completes unchanged.
REQ-032: NOP accepted -> no out_valid; seq_done pulses within 2 cycles; op_ready high again next cycle.
REQ-033: op_code 3 -> err=1, op_ready=0 persist until rst; a later ROM returning FFFFFFFF on the IADD step 2 -> err=1 and only the first word emitted.
REQ-034: rst pulsed during WAIT of IADD step 1 -> out_valid 0 immediately, no seq_done, and a new IADD then runs fully.
REQ-035: With COM_SEQ_SKIP_ZERO_EN and ROM addr 2 = 32'h0, IADD -> only E83D0003, E9AD0001 emitted; without the macro, 00000000 is emitted between them.
